// File: rtl/birthday_seq_ctrl_if.sv
// rtl/birthday_seq_ctrl_if.sv - digit lookup bus between the sequencer and the combinational digit ROM
//   rom_idx   : 3-bit index driven by the sequencer (master)
//   rom_digit : 4-bit digit returned by the lookup in the same cycle (slave)
interface birthday_seq_ctrl_if;
    logic [2:0] rom_idx;
    logic [3:0] rom_digit;

    modport master (
        output rom_idx,
        input  rom_digit
    );

    modport slave (
        input  rom_idx,
        output rom_digit
    );
endinterface

// File: rtl/birthday_seq_ctrl.sv
// rtl/birthday_seq_ctrl.sv - birthday digit sequencer with rate divider, pause/step and scroll window
//   CLK, rst_n  : clock, asynchronous active-low reset
//   start       : level; starts a run from IDLE, resumes from HOLD
//   stop        : level; pauses a run, wins over start
//   step        : level; one advance per cycle in IDLE or HOLD
//   loop_en     : 1 = wrap and keep running, 0 = end after the last digit
//   div         : tick period is div+1 clocks
//   rom         : digit lookup bus (index out, digit back same cycle)
//   digit_out   : last captured digit
//   digit_valid : one-cycle strobe when digit_out updates
//   disp        : 4-digit scroll window, newest digit in [3:0]
//   busy        : high in RUN or HOLD
//   done        : one-cycle pulse at the end of a one-shot run
module birthday_seq_ctrl #(
    parameter int DIV_W      = 4,
    parameter int NUM_DIGITS = 8
) (
    input  logic                       CLK,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic                       stop,
    input  logic                       step,
    input  logic                       loop_en,
    input  logic [DIV_W-1:0]           div,
    birthday_seq_ctrl_if.master        rom,
    output logic [3:0]                 digit_out,
    output logic                       digit_valid,
    output logic [15:0]                disp,
    output logic                       busy,
    output logic                       done
);

    localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [DIV_W-1:0] r_pre;
    logic [2:0]       r_idx;
    logic [3:0]       r_digit;
    logic             r_valid;
    logic [15:0]      r_disp;
    logic             r_busy;
    logic             r_done;

    state_t           w_state_nxt;
    logic [DIV_W-1:0] w_pre_nxt;
    logic             w_adv;
    logic             w_at_last;

    assign w_at_last = (r_idx == LAST_IDX);

    // Next-state, prescaler and advance decision. The prescaler defaults to
    // zero so it is cleared in every state except an uninterrupted RUN.
    always_comb begin
        w_state_nxt = r_state;
        w_pre_nxt   = '0;
        w_adv       = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    w_state_nxt = S_RUN;
                end else if (step && !start) begin
                    w_adv = 1'b1;
                end
            end
            S_RUN: begin
                if (stop) begin
                    // A tick landing on the same edge as stop is dropped.
                    w_state_nxt = S_HOLD;
                end else if (r_pre > div) begin
                    // div shrank below the running count: restart without a tick.
                    w_pre_nxt = '0;
                end else if (r_pre == div) begin
                    w_adv = 1'b1;
                    if (w_at_last && !loop_en) begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_pre_nxt = r_pre + 1'b1;
                end
            end
            S_HOLD: begin
                if (start && !stop) begin
                    w_state_nxt = S_RUN;
                end else if (step && !start) begin
                    // Stepping may wrap the index but never finishes the run.
                    w_adv = 1'b1;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pre   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pre   <= w_pre_nxt;
        end
    end

    // Datapath: capture the looked-up digit, shift the window, bump the index.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_digit <= '0;
            r_valid <= 1'b0;
            r_disp  <= '0;
        end else begin
            r_valid <= w_adv;
            if (w_adv) begin
                r_digit <= rom.rom_digit;
                r_disp  <= {r_disp[11:0], rom.rom_digit};
                r_idx   <= w_at_last ? 3'd0 : r_idx + 3'd1;
            end
        end
    end

    // Status flags are registered from the next state so they line up with
    // the state they describe.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == S_RUN) || (w_state_nxt == S_HOLD);
            r_done <= (w_state_nxt == S_DONE);
        end
    end

    assign rom.rom_idx = r_idx;
    assign digit_out   = r_digit;
    assign digit_valid = r_valid;
    assign disp        = r_disp;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule

// File: tb/tb_birthday_seq_ctrl.sv
// tb/tb_birthday_seq_ctrl.sv - directed self-checking bench for birthday_seq_ctrl
module tb_birthday_seq_ctrl;

    logic        CLK = 1'b0;
    logic        rst_n;
    logic        start;
    logic        stop;
    logic        step;
    logic        loop_en;
    logic [3:0]  div;
    logic [3:0]  digit_out;
    logic        digit_valid;
    logic [15:0] disp;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    birthday_seq_ctrl_if rom_bus ();

    // Lookup model: digit = index + 1.
    assign rom_bus.rom_digit = {1'b0, rom_bus.rom_idx} + 4'd1;

    birthday_seq_ctrl #(
        .DIV_W      (4),
        .NUM_DIGITS (8)
    ) dut (
        .CLK         (CLK),
        .rst_n       (rst_n),
        .start       (start),
        .stop        (stop),
        .step        (step),
        .loop_en     (loop_en),
        .div         (div),
        .rom         (rom_bus),
        .digit_out   (digit_out),
        .digit_valid (digit_valid),
        .disp        (disp),
        .busy        (busy),
        .done        (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clk1();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        start   = 1'b0;
        stop    = 1'b0;
        step    = 1'b0;
        loop_en = 1'b0;
        div     = 4'd0;
        rst_n   = 1'b0;
        clk1();
        clk1();
        rst_n   = 1'b1;
    endtask

    initial begin
        int cnt;
        int last;
        int seen;
        int bad;

        start   = 1'b0;
        stop    = 1'b0;
        step    = 1'b0;
        loop_en = 1'b0;
        div     = 4'd0;
        rst_n   = 1'b0;
        #2;
        check("rst digit_out", digit_out, 4'd0);
        check("rst valid", digit_valid, 1'b0);
        check("rst disp", disp, 16'h0000);
        check("rst busy", busy, 1'b0);
        check("rst done", done, 1'b0);
        check("rst idx", rom_bus.rom_idx, 3'd0);

        // One-shot, div=0.
        do_reset();
        loop_en = 1'b0;
        div     = 4'd0;
        start   = 1'b1;
        clk1();
        start   = 1'b0;
        check("os busy after start", busy, 1'b1);
        check("os no strobe edge0", digit_valid, 1'b0);
        for (int e = 1; e <= 8; e++) begin
            clk1();
            check($sformatf("os valid e%0d", e), digit_valid, 1'b1);
            check($sformatf("os digit e%0d", e), digit_out, 32'(e));
        end
        check("os done pulse", done, 1'b1);
        check("os disp", disp, 16'h5678);
        check("os busy in done", busy, 1'b0);
        clk1();
        check("os done cleared", done, 1'b0);
        check("os busy idle", busy, 1'b0);
        check("os idx idle", rom_bus.rom_idx, 3'd0);
        check("os no strobe idle", digit_valid, 1'b0);
        check("os disp retained", disp, 16'h5678);

        // Loop, div=2, 20 strobes.
        do_reset();
        loop_en = 1'b1;
        div     = 4'd2;
        start   = 1'b1;
        clk1();
        start   = 1'b0;
        cnt  = 0;
        last = 0;
        seen = 0;
        bad  = 0;
        for (int c = 1; c <= 80 && cnt < 20; c++) begin
            clk1();
            if (digit_valid) begin
                check($sformatf("loop digit %0d", cnt), digit_out, 32'((cnt % 8) + 1));
                check($sformatf("loop gap %0d", cnt), 32'(c - last), 32'd3);
                last = c;
                cnt++;
            end
            if (done) seen = 1;
            if (!busy) bad = 1;
        end
        check("loop strobe count", cnt, 20);
        check("loop no done", seen, 0);
        check("loop busy held", bad, 0);

        // Pause/resume, div=1.
        do_reset();
        loop_en = 1'b1;
        div     = 4'd1;
        start   = 1'b1;
        clk1();
        start   = 1'b0;
        cnt = 0;
        for (int c = 0; c < 20 && cnt < 3; c++) begin
            clk1();
            if (digit_valid) cnt++;
        end
        check("pause 3 strobes", cnt, 3);
        check("pause digit3", digit_out, 4'd3);
        stop = 1'b1;
        clk1();
        stop = 1'b0;
        check("pause busy", busy, 1'b1);
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            clk1();
            if (digit_valid) seen++;
        end
        check("pause no strobes", seen, 0);
        check("pause idx held", rom_bus.rom_idx, 3'd3);
        check("pause busy held", busy, 1'b1);
        start = 1'b1;
        clk1();
        start = 1'b0;
        check("resume no strobe edge0", digit_valid, 1'b0);
        clk1();
        check("resume no strobe edge1", digit_valid, 1'b0);
        clk1();
        check("resume strobe edge2", digit_valid, 1'b1);
        check("resume digit4", digit_out, 4'd4);

        // Step in HOLD across the wrap.
        stop = 1'b1;
        clk1();
        stop = 1'b0;
        check("hold idx", rom_bus.rom_idx, 3'd4);
        step = 1'b1;
        for (int k = 5; k <= 7; k++) begin
            clk1();
            check($sformatf("step valid %0d", k), digit_valid, 1'b1);
            check($sformatf("step digit %0d", k), digit_out, 32'(k));
        end
        check("step idx7", rom_bus.rom_idx, 3'd7);
        clk1();
        step = 1'b0;
        check("step wrap digit", digit_out, 4'd8);
        check("step wrap idx", rom_bus.rom_idx, 3'd0);
        check("step wrap no done", done, 1'b0);
        check("step wrap busy", busy, 1'b1);
        clk1();
        check("step released no strobe", digit_valid, 1'b0);
        check("step still hold", busy, 1'b1);
        check("step disp", disp, 16'h5678);

        // div shrinks below the running count: wrap without tick.
        do_reset();
        loop_en = 1'b1;
        div     = 4'd7;
        start   = 1'b1;
        clk1();
        start   = 1'b0;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            clk1();
            if (digit_valid) seen++;
        end
        div = 4'd2;
        for (int c = 0; c < 3; c++) begin
            clk1();
            if (digit_valid) seen++;
        end
        check("div shrink no early tick", seen, 0);
        clk1();
        check("div shrink tick", digit_valid, 1'b1);
        check("div shrink digit", digit_out, 4'd1);

        // start and stop together in IDLE, then a step in IDLE.
        do_reset();
        start = 1'b1;
        stop  = 1'b1;
        seen  = 0;
        bad   = 0;
        for (int c = 0; c < 3; c++) begin
            clk1();
            if (digit_valid) seen++;
            if (busy) bad = 1;
        end
        start = 1'b0;
        stop  = 1'b0;
        check("ss no strobe", seen, 0);
        check("ss not busy", bad, 0);
        check("ss idx", rom_bus.rom_idx, 3'd0);
        step = 1'b1;
        clk1();
        step = 1'b0;
        check("idle step valid", digit_valid, 1'b1);
        check("idle step digit", digit_out, 4'd1);
        check("idle step idx", rom_bus.rom_idx, 3'd1);
        check("idle step busy", busy, 1'b0);
        clk1();
        check("idle step one strobe", digit_valid, 1'b0);

        // Reset mid-run at rom_idx=5.
        do_reset();
        loop_en = 1'b1;
        div     = 4'd0;
        start   = 1'b1;
        clk1();
        start   = 1'b0;
        for (int c = 0; c < 20 && rom_bus.rom_idx != 3'd5; c++) begin
            clk1();
        end
        check("mid idx5", rom_bus.rom_idx, 3'd5);
        rst_n = 1'b0;
        #1;
        check("mid rst digit_out", digit_out, 4'd0);
        check("mid rst valid", digit_valid, 1'b0);
        check("mid rst disp", disp, 16'h0000);
        check("mid rst busy", busy, 1'b0);
        check("mid rst done", done, 1'b0);
        check("mid rst idx", rom_bus.rom_idx, 3'd0);
        clk1();
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            clk1();
            if (digit_valid) seen++;
        end
        check("mid post rst no strobe", seen, 0);
        check("mid post rst busy", busy, 1'b0);
        check("mid post rst idx", rom_bus.rom_idx, 3'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/birthday_seq_ctrl.md
Name: birthday_seq_ctrl

Overview:
- Sequencer for the Lab5 birthday digit display.
- Drives the 3-bit index into the combinational digit lookup and samples the 4-bit digit it returns at a programmable rate.
- Presents each digit as a one-cycle valid strobe and keeps a 4-digit scrolling window for the display stage.
- Supports run, pause/resume, single-step, and loop or one-shot modes.

Parameters:
- DIV_W, 4: width of the rate divider input `div`.
- NUM_DIGITS, 8: sequence length. Legal range 1..8; `rom_idx` wraps at NUM_DIGITS-1.

Ports:
- CLK  in  1  system clock; all state changes on the posedge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  level. In IDLE, starts a run; in HOLD, resumes.
- stop  in  1  level. In RUN, pauses. Has priority over start.
- step  in  1  level. In IDLE or HOLD, performs one advance.
- loop_en  in  1  1 = wrap and continue; 0 = one-shot, ends after the last index.
- div  in  DIV_W  tick period is div+1 clocks. Sampled every cycle.
- rom_idx  out  3  index to the digit lookup.
- rom_digit  in  4  digit returned by the lookup for rom_idx; combinational, same cycle.
- digit_out  out  4  last captured digit.
- digit_valid  out  1  one-cycle strobe when digit_out updates.
- disp  out  16  scroll window; newest digit in [3:0].
- busy  out  1  high in RUN or HOLD.
- done  out  1  one-cycle pulse at the end of a one-shot run.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; pre=0; rom_idx=0; digit_out=0; digit_valid=0; disp=16'h0000; busy=0; done=0.
  - Takes effect immediately, mid-run included. Operation resumes only after rst_n deasserts and start is seen.
- States: IDLE, RUN, HOLD, DONE. All outputs are registered.
- Prescaler `pre`, DIV_W bits:
  - Counts only in RUN and is cleared in every other state.
  - Tick when pre==div; pre then returns to 0.
  - If div changes so that pre>div, pre wraps to 0 without a tick.
- Advance (on a tick, or on an accepted step), at one clock edge:
  - digit_out <= rom_digit
  - digit_valid <= 1
  - disp <= {disp[11:0], rom_digit}
  - rom_idx <= (rom_idx==NUM_DIGITS-1) ? 0 : rom_idx+1
- IDLE:
  - start=1 and stop=0: go to RUN with pre=0.
  - step=1 with start=0: one advance, stay in IDLE.
  - stop alone: ignored.
- RUN:
  - stop=1: go to HOLD, pre cleared, rom_idx held. A tick coinciding with stop is dropped.
  - start and step are ignored.
  - Tick at rom_idx==NUM_DIGITS-1 with loop_en=0: advance and go to DONE.
  - Tick at rom_idx==NUM_DIGITS-1 with loop_en=1: advance and stay in RUN.
- HOLD:
  - start=1 and stop=0: return to RUN with pre=0.
  - step=1 with start=0: one advance, stay in HOLD. Wrap is allowed; step never causes DONE.
- DONE:
  - Lasts exactly one cycle with done=1, then IDLE.
  - rom_idx is already 0. disp and digit_out are retained.
- Latency:
  - First digit_valid is asserted after the div+1-th edge following the edge that samples start.
  - Subsequent strobes arrive every div+1 clocks.
  - Step strobes one edge after step is sampled.
- Level inputs held high re-trigger: step held in HOLD advances every cycle.

Test Plan:
- Bench lookup model: rom_digit = rom_idx+1.
- One-shot, div=0, loop_en=0, one-cycle start at edge 0:
  - digit_valid at edges 1..8 with digit_out=1..8.
  - done=1 in the cycle after edge 8; disp=16'h5678.
  - IDLE after edge 9; busy=0; rom_idx=0.
- Loop, div=2, loop_en=1, 20 strobes:
  - Strobes exactly 3 clocks apart.
  - Digits 1..8,1..8,1..4; done never asserted; busy stays 1.
- Pause/resume, div=1:
  - stop after the 3rd strobe: busy=1, no strobes for 10 cycles, rom_idx=3 held.
  - start: next strobe 2 clocks later with digit 4.
- Step in HOLD at rom_idx=7: digit_out=8, rom_idx=0, no done, state stays HOLD.
- start and stop both high in IDLE: stays IDLE, busy=0, no strobe.
- rst_n low mid-run at rom_idx=5: all outputs zero immediately; no strobe until a new start.
